// File: rtl/mc_alu_control.sv
// Multi-cycle ALU control and datapath: single-cycle RV32I/RV64I integer ops plus
// iterative shift-add multiply and restoring divide, behind a valid/ready handshake.
module mc_alu_control #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal,
    output logic [1:0]      dbg_state_o
);

    // Handshake: a request transfers on a rising edge where in_valid && in_ready;
    // a result transfers where out_valid && out_ready, and is held until then.

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
    } op_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   opb_q;
    logic              neg_q;
    logic              neg_rem_q;
    logic              sel_q;
    logic [XLEN-1:0]   result_q;
    logic              illegal_q;

    function automatic op_t base_op(input logic [2:0] f3, input logic arith);
        op_t o;
        case (f3)
            3'b000:  o = OP_ADD;
            3'b001:  o = OP_SLL;
            3'b010:  o = OP_SLT;
            3'b011:  o = OP_SLTU;
            3'b100:  o = OP_XOR;
            3'b101:  o = arith ? OP_SRA : OP_SRL;
            3'b110:  o = OP_OR;
            default: o = OP_AND;
        endcase
        return o;
    endfunction

    function automatic op_t m_op(input logic [2:0] f3);
        op_t o;
        case (f3)
            3'b000:  o = OP_MUL;
            3'b001:  o = OP_MULH;
            3'b010:  o = OP_MULHSU;
            3'b011:  o = OP_MULHU;
            3'b100:  o = OP_DIV;
            3'b101:  o = OP_DIVU;
            3'b110:  o = OP_REM;
            default: o = OP_REMU;
        endcase
        return o;
    endfunction

    op_t dec_op;

    always_comb begin
        dec_op = OP_ILL;
        case (alu_op)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                if (funct7 == 7'b0000000) begin
                    dec_op = base_op(funct3, 1'b0);
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000)      dec_op = OP_SUB;
                    else if (funct3 == 3'b101) dec_op = OP_SRA;
                end else if (funct7 == 7'b0000001) begin
                    dec_op = m_op(funct3);
                end
            end
            // I-type: funct7 carries immediate bits, only bit 5 matters for shifts
            default: dec_op = base_op(funct3, funct7[5]);
        endcase
    end

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;

    assign shamt = src_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (dec_op)
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_SLL:  alu_res = src_a << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SRL:  alu_res = src_a >> shamt;
            OP_SRA:  alu_res = XLEN'($signed(src_a) >>> shamt);
            OP_OR:   alu_res = src_a | src_b;
            OP_AND:  alu_res = src_a & src_b;
            default: alu_res = '0;
        endcase
    end

    logic            is_mul;
    logic            is_div;
    logic            is_rem;
    logic            a_sgn;
    logic            b_sgn;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            op_neg;
    logic            op_neg_rem;
    logic            div_zero;
    logic            div_ovf;

    always_comb begin
        is_mul = (dec_op == OP_MUL) || (dec_op == OP_MULH) ||
                 (dec_op == OP_MULHSU) || (dec_op == OP_MULHU);
        is_div = (dec_op == OP_DIV) || (dec_op == OP_DIVU) ||
                 (dec_op == OP_REM) || (dec_op == OP_REMU);
        is_rem = (dec_op == OP_REM) || (dec_op == OP_REMU);
        a_sgn  = (dec_op == OP_MULH) || (dec_op == OP_MULHSU) ||
                 (dec_op == OP_DIV) || (dec_op == OP_REM);
        b_sgn  = (dec_op == OP_MULH) || (dec_op == OP_DIV) || (dec_op == OP_REM);
        mag_a  = (a_sgn && src_a[XLEN-1]) ? -src_a : src_a;
        mag_b  = (b_sgn && src_b[XLEN-1]) ? -src_b : src_b;
        op_neg     = (a_sgn & src_a[XLEN-1]) ^ (b_sgn & src_b[XLEN-1]);
        op_neg_rem = a_sgn & src_a[XLEN-1];
        div_zero   = (src_b == '0);
        div_ovf    = b_sgn && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
    end

    // Multiply: prod_q = {accumulator, multiplier}; add multiplicand on LSB, shift right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] mul_fix;
    logic [XLEN-1:0]   mul_out;

    assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, prod_q[XLEN-1:1]};
    assign mul_fix  = neg_q ? -mul_next : mul_next;
    assign mul_out  = sel_q ? mul_fix[2*XLEN-1:XLEN] : mul_fix[XLEN-1:0];

    // Divide: prod_q = {partial remainder, dividend/quotient}; shift left, trial subtract.
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   div_out;

    assign div_shift = prod_q[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    assign quo_fix   = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
    assign rem_fix   = neg_rem_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
    assign div_out   = sel_q ? rem_fix : quo_fix;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            prod_q    <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            sel_q     <= 1'b0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        illegal_q <= 1'b0;
                        cnt_q     <= '0;
                        if (dec_op == OP_ILL) begin
                            illegal_q <= 1'b1;
                            result_q  <= '0;
                            state_q   <= S_DONE;
                        end else if (is_mul) begin
                            prod_q    <= {{XLEN{1'b0}}, mag_a};
                            opb_q     <= mag_b;
                            neg_q     <= op_neg;
                            neg_rem_q <= 1'b0;
                            sel_q     <= (dec_op != OP_MUL);
                            state_q   <= S_MUL;
                        end else if (is_div) begin
                            if (div_zero) begin
                                result_q <= is_rem ? src_a : '1;
                                state_q  <= S_DONE;
                            end else if (div_ovf) begin
                                result_q <= is_rem ? '0 : src_a;
                                state_q  <= S_DONE;
                            end else begin
                                prod_q    <= {{XLEN{1'b0}}, mag_a};
                                opb_q     <= mag_b;
                                neg_q     <= op_neg;
                                neg_rem_q <= op_neg_rem;
                                sel_q     <= is_rem;
                                state_q   <= S_DIV;
                            end
                        end else begin
                            result_q <= alu_res;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    prod_q <= mul_next;
                    cnt_q  <= cnt_q + CW'(1);
                    // Last step and sign correction share one edge so latency is XLEN+1
                    if (cnt_q == CW'(XLEN-1)) begin
                        result_q <= mul_out;
                        state_q  <= S_DONE;
                    end
                end
                S_DIV: begin
                    prod_q <= div_next;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN-1)) begin
                        result_q <= div_out;
                        state_q  <= S_DONE;
                    end
                end
                default: begin
                    if (out_ready) state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign result      = result_q;
    assign illegal     = illegal_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mc_alu_control.sv
// Bench for mc_alu_control (XLEN=32): directed corner cases plus random requests
// compared against an arithmetic reference model.
module tb_mc_alu_control;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        illegal;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    mc_alu_control #(.XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .illegal(illegal),
        .dbg_state_o(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] base_ref(input logic [2:0] f3, input logic arith,
                                             input logic [31:0] a, input logic [31:0] b);
        int sa = a;
        int sb = b;
        int sh = int'(b[4:0]);
        logic [31:0] r;
        case (f3)
            3'd0:    r = a + b;
            3'd1:    r = a << sh;
            3'd2:    r = (sa < sb) ? 32'd1 : 32'd0;
            3'd3:    r = (a < b) ? 32'd1 : 32'd0;
            3'd4:    r = a ^ b;
            3'd5:    r = arith ? 32'(sa >>> sh) : (a >> sh);
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    task automatic model(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic ill, output int lat);
        int sa = a;
        int sb = b;
        longint p;
        logic [63:0] u;
        bit ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r = '0; ill = 1'b0; lat = 1;
        case (op)
            2'd0: r = a + b;
            2'd1: r = a - b;
            2'd2: begin
                if (f7 == 7'h00) r = base_ref(f3, 1'b0, a, b);
                else if (f7 == 7'h20 && f3 == 3'd0) r = a - b;
                else if (f7 == 7'h20 && f3 == 3'd5) r = base_ref(f3, 1'b1, a, b);
                else if (f7 == 7'h01) begin
                    lat = 33;
                    case (f3)
                        3'd0: begin u = {32'd0, a} * {32'd0, b}; r = u[31:0]; end
                        3'd1: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
                        3'd2: begin p = longint'(sa) * longint'({32'd0, b}); r = p[63:32]; end
                        3'd3: begin u = {32'd0, a} * {32'd0, b}; r = u[63:32]; end
                        3'd4: if (b == 0) begin r = '1; lat = 1; end
                              else if (ovf) begin r = a; lat = 1; end
                              else r = sa / sb;
                        3'd5: if (b == 0) begin r = '1; lat = 1; end
                              else r = a / b;
                        3'd6: if (b == 0) begin r = a; lat = 1; end
                              else if (ovf) begin r = '0; lat = 1; end
                              else r = sa % sb;
                        default: if (b == 0) begin r = a; lat = 1; end
                                 else r = a % b;
                    endcase
                end else ill = 1'b1;
            end
            default: r = base_ref(f3, f7[5], a, b);
        endcase
    endtask

    task automatic drive_op(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] er, input logic eill, input int elat,
                            input int hold, input bit poke);
        int g;
        int lat;
        logic [31:0] exp_r;
        exp_q.push_back(er);
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("in_ready_idle", in_ready, 1);
        alu_op = op; funct7 = f7; funct3 = f3; src_a = a; src_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src_a = $urandom; src_b = $urandom; funct3 = 3'($urandom); funct7 = 7'($urandom);
        alu_op = 2'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && poke) in_valid = 1'($urandom_range(0, 1));
        end while (!out_valid && lat < 100);
        in_valid = 1'b0;
        exp_r = exp_q.pop_front();
        check("latency", lat, elat);
        check("result", result, exp_r);
        check("illegal", illegal, eill);
        check("in_ready_busy", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            if (poke) in_valid = 1'b1;
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_result", result, exp_r);
            check("hold_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_ready", in_ready, 1);
        check("release_valid", out_valid, 0);
    endtask

    task automatic run_model(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b, input int hold,
                             input bit poke);
        logic [31:0] r;
        logic ill;
        int lat;
        model(op, f7, f3, a, b, r, ill, lat);
        drive_op(op, f7, f3, a, b, r, ill, lat, hold, poke);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        bit seen_valid;
        logic [6:0] f7;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = '0; funct7 = '0; funct3 = '0; src_a = '0; src_b = '0;
        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_illegal", illegal, 0);
        check("rst_state", dbg_state, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        drive_op(2'd2, 7'h20, 3'd0, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1, 0, 0);
        drive_op(2'd2, 7'h01, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33, 0, 1);
        drive_op(2'd2, 7'h01, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, 0, 1);
        drive_op(2'd2, 7'h01, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, 0, 0);
        drive_op(2'd2, 7'h01, 3'd5, 32'd123, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, 0, 0);
        drive_op(2'd2, 7'h01, 3'd7, 32'd123, 32'd0, 32'd123, 1'b0, 1, 0, 0);
        drive_op(2'd2, 7'h01, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, 0, 0);
        drive_op(2'd2, 7'h01, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1, 0, 0);
        drive_op(2'd2, 7'h20, 3'd4, 32'd9, 32'd3, 32'h0, 1'b1, 1, 0, 0);
        drive_op(2'd3, 7'h20, 3'd5, 32'h8000_0010, 32'd4, 32'hF800_0001, 1'b0, 1, 5, 1);
        drive_op(2'd3, 7'h20, 3'd0, 32'd10, 32'hFFFF_FFFF, 32'd9, 1'b0, 1, 0, 0);

        // Reset in the middle of a multiply
        @(negedge clk);
        alu_op = 2'd2; funct7 = 7'h01; funct3 = 3'd0; src_a = 32'd7; src_b = 32'd6;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_result", result, 0);
        check("midrst_state", dbg_state, 0);
        @(negedge clk);
        reset_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("midrst_no_valid", seen_valid, 0);
        drive_op(2'd0, 7'h00, 3'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1, 0, 0);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                2:       f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            run_model(2'($urandom_range(0, 3)), f7, 3'($urandom_range(0, 7)), pick(), pick(),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
